// File: rtl/pipelined_product_accumulator.sv
// Sums a programmed number of multiplier products into a wide accumulator and
// holds the result on a valid/ready port; optional SATURATE_EN clamps on carry-out.
module pipelined_product_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    start_i,
    input  logic [CNT_WIDTH-1:0]    length_i,
    input  logic [2*DATA_WIDTH-1:0] product_i,
    input  logic                    product_valid_i,
    output logic                    clk_en_o,
    output logic [ACC_WIDTH-1:0]    result_o,
    output logic                    result_valid_o,
    input  logic                    result_ready_i,
    output logic                    busy_o,
    output logic                    overflow_o,
    output logic                    drop_o,
    output logic [1:0]              dbg_state_o
);

    localparam int PW = 2*DATA_WIDTH;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

    // Handshake: result_o is transferred on any edge where result_valid_o and
    // result_ready_i are both high; products count only while clk_en_o is high.
    logic [1:0]           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 drop_q, drop_d;
    logic [ACC_WIDTH:0]   sum;
    logic                 take_start;

    assign sum = {1'b0, acc_q} + {{(ACC_WIDTH+1-PW){1'b0}}, product_i};

    // A start is legal in IDLE, or in DONE on the same edge as the handshake.
    assign take_start = start_i &&
                        ((state_q == S_IDLE) || ((state_q == S_DONE) && result_ready_i));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;
        if (take_start) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            drop_d  = 1'b0;
            cnt_d   = length_i;
            state_d = (length_i != CNT_ZERO) ? S_ACCUM : S_DONE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (product_valid_i) drop_d = 1'b1;
                end
                S_ACCUM: begin
                    if (product_valid_i) begin
                        cnt_d = cnt_q - CNT_ONE;
                        ovf_d = ovf_q | sum[ACC_WIDTH];
`ifdef SATURATE_EN
                        acc_d = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
                        acc_d = sum[ACC_WIDTH-1:0];
`endif
                        if (cnt_q == CNT_ONE) state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    // Products held by the frozen pipeline are not counted here.
                    if (result_ready_i) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    assign clk_en_o       = (state_q != S_DONE);
    assign result_valid_o = (state_q == S_DONE);
    assign busy_o         = (state_q != S_IDLE);
    assign result_o       = acc_q;
    assign overflow_o     = ovf_q;
    assign drop_o         = drop_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_pipelined_product_accumulator.sv
// Bench for pipelined_product_accumulator: a 40-bit and a 33-bit accumulator
// share stimulus and are compared every cycle against an unbounded-sum model.
module tb_pipelined_product_accumulator;

    localparam int DW = 16;
    localparam int CW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic [31:0] prod = '0;
    logic        pvalid = 1'b0;
    logic        ready = 1'b0;

    logic        clk_en_a, valid_a, busy_a, ovf_a, drop_a;
    logic [39:0] res_a;
    logic [1:0]  dbg_a;
    logic        clk_en_b, valid_b, busy_b, ovf_b, drop_b;
    logic [32:0] res_b;
    logic [1:0]  dbg_b;

    int n_checks = 0;
    int n_err = 0;
    logic cmp_en = 1'b0;

    pipelined_product_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(40), .CNT_WIDTH(CW)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .length_i(len),
        .product_i(prod), .product_valid_i(pvalid), .clk_en_o(clk_en_a),
        .result_o(res_a), .result_valid_o(valid_a), .result_ready_i(ready),
        .busy_o(busy_a), .overflow_o(ovf_a), .drop_o(drop_a), .dbg_state_o(dbg_a)
    );

    pipelined_product_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(33), .CNT_WIDTH(CW)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .length_i(len),
        .product_i(prod), .product_valid_i(pvalid), .clk_en_o(clk_en_b),
        .result_o(res_b), .result_valid_o(valid_b), .result_ready_i(ready),
        .busy_o(busy_b), .overflow_o(ovf_b), .drop_o(drop_b), .dbg_state_o(dbg_b)
    );

    always #5 clk = ~clk;

    // Model: job phase, products still owed, and the true (unbounded) sum.
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;
    int          m_phase;
    int          m_rem;
    logic [63:0] m_sum;
    logic        m_drop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= M_IDLE;
            m_rem   <= 0;
            m_sum   <= '0;
            m_drop  <= 1'b0;
        end else if ((m_phase == M_IDLE && start) || (m_phase == M_DONE && ready && start)) begin
            m_drop  <= 1'b0;
            m_sum   <= '0;
            m_rem   <= int'(len);
            m_phase <= (len != 8'd0) ? M_RUN : M_DONE;
        end else if (m_phase == M_IDLE) begin
            if (pvalid) m_drop <= 1'b1;
        end else if (m_phase == M_RUN) begin
            if (pvalid) begin
                m_sum <= m_sum + {32'd0, prod};
                m_rem <= m_rem - 1;
                if (m_rem == 1) m_phase <= M_DONE;
            end
        end else if (ready) begin
            m_phase <= M_IDLE;
        end
    end

    function automatic logic [63:0] lim(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] exp_res(input logic [63:0] s, input int w);
`ifdef SATURATE_EN
        return (s > lim(w)) ? lim(w) : s;
`else
        return s & lim(w);
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("clk_en_a", {63'd0, clk_en_a}, {63'd0, m_phase != M_DONE});
            chk("valid_a",  {63'd0, valid_a},  {63'd0, m_phase == M_DONE});
            chk("busy_a",   {63'd0, busy_a},   {63'd0, m_phase != M_IDLE});
            chk("result_a", {24'd0, res_a},    exp_res(m_sum, 40));
            chk("ovf_a",    {63'd0, ovf_a},    {63'd0, m_sum > lim(40)});
            chk("drop_a",   {63'd0, drop_a},   {63'd0, m_drop});
            chk("clk_en_b", {63'd0, clk_en_b}, {63'd0, m_phase != M_DONE});
            chk("valid_b",  {63'd0, valid_b},  {63'd0, m_phase == M_DONE});
            chk("busy_b",   {63'd0, busy_b},   {63'd0, m_phase != M_IDLE});
            chk("result_b", {31'd0, res_b},    exp_res(m_sum, 33));
            chk("ovf_b",    {63'd0, ovf_b},    {63'd0, m_sum > lim(33)});
            chk("drop_b",   {63'd0, drop_b},   {63'd0, m_drop});
        end
    end

    task automatic drive(input logic s, input logic [7:0] l, input logic v,
                         input logic [31:0] p, input logic r);
        @(negedge clk);
        start  = s;
        len    = l;
        pvalid = v;
        prod   = p;
        ready  = r;
    endtask

    task automatic idle();
        drive(1'b0, 8'd0, 1'b0, 32'd0, 1'b0);
    endtask

    logic        r_s, r_v, r_r;
    logic [7:0]  r_l;
    logic [31:0] r_p;

    initial begin
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_clk_en", {63'd0, clk_en_a}, 64'd1);
        chk("rst_result", {24'd0, res_a}, 64'd0);
        chk("rst_flags", {59'd0, valid_a, busy_a, ovf_a, drop_a, clk_en_b ^ 1'b1}, 64'd0);
        rst_n = 1'b1;
        idle();

        // Three-product job: 2 + 3 + 4, then five stalled DONE cycles with a held product.
        drive(1'b1, 8'd3, 1'b0, 32'd0, 1'b0);
        drive(1'b0, 8'd0, 1'b1, 32'd2, 1'b0);
        drive(1'b0, 8'd0, 1'b1, 32'd3, 1'b0);
        drive(1'b0, 8'd0, 1'b1, 32'd4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'd0, 1'b1, 32'd5, 1'b0);
            chk("job3_result", {24'd0, res_a}, 64'd9);
            chk("job3_valid_clken", {62'd0, valid_a, clk_en_a}, 64'd2);
        end
        chk("model_sum9", m_sum, 64'd9);
        drive(1'b0, 8'd0, 1'b1, 32'd5, 1'b1);
        idle();
        chk("after_hs", {61'd0, valid_a, busy_a, clk_en_a}, 64'd1);

        // Zero-length job, then a product arriving while idle.
        drive(1'b1, 8'd0, 1'b0, 32'd0, 1'b0);
        idle();
        chk("len0_result", {24'd0, res_a}, 64'd0);
        chk("len0_valid", {63'd0, valid_a}, 64'd1);
        drive(1'b0, 8'd0, 1'b0, 32'd0, 1'b1);
        drive(1'b0, 8'd0, 1'b1, 32'd3, 1'b0);
        idle();
        chk("drop_set", {62'd0, drop_a, drop_b}, 64'd3);
        idle();
        chk("drop_sticky", {63'd0, drop_a}, 64'd1);

        // Back-to-back jobs: handshake with start, next product 7.
        drive(1'b1, 8'd1, 1'b0, 32'd0, 1'b0);
        drive(1'b0, 8'd0, 1'b1, 32'd6, 1'b0);
        chk("drop_cleared", {63'd0, drop_a}, 64'd0);
        drive(1'b1, 8'd1, 1'b1, 32'd7, 1'b1);
        chk("b2b_first", {24'd0, res_a}, 64'd6);
        drive(1'b0, 8'd0, 1'b1, 32'd7, 1'b0);
        chk("b2b_no_idle", {62'd0, busy_a, valid_a}, 64'd2);
        idle();
        chk("b2b_second", {24'd0, res_a}, 64'd7);
        chk("model_sum7", m_sum, 64'd7);
        drive(1'b0, 8'd0, 1'b0, 32'd0, 1'b1);
        idle();

        // 255 all-ones products: fits 40 bits, overflows 33 bits.
        drive(1'b1, 8'd255, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 255; i++) drive(1'b0, 8'd0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        idle();
        chk("full40_result", {24'd0, res_a}, 64'h00FE_FFFF_FF01);
        chk("full40_ovf", {63'd0, ovf_a}, 64'd0);
`ifdef SATURATE_EN
        chk("full33_result", {31'd0, res_b}, 64'h1_FFFF_FFFF);
`else
        chk("full33_result", {31'd0, res_b}, 64'h0_FFFF_FF01);
`endif
        chk("full33_ovf", {63'd0, ovf_b}, 64'd1);
        chk("model_full", m_sum, 64'h00FE_FFFF_FF01);
        drive(1'b0, 8'd0, 1'b0, 32'd0, 1'b1);
        idle();

        // Asynchronous reset in the middle of a job.
        drive(1'b1, 8'd5, 1'b0, 32'd0, 1'b0);
        drive(1'b0, 8'd0, 1'b1, 32'd10, 1'b0);
        drive(1'b0, 8'd0, 1'b1, 32'd10, 1'b0);
        @(posedge clk);
        #2;
        chk("pre_rst_result", {24'd0, res_a}, 64'd20);
        rst_n = 1'b0;
        #1;
        chk("async_rst_result", {24'd0, res_a}, 64'd0);
        chk("async_rst_flags", {60'd0, busy_a, valid_a, ovf_a, drop_a}, 64'd0);
        chk("async_rst_clk_en", {63'd0, clk_en_a}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r_s = ($urandom_range(0, 5) == 0);
            r_l = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 8));
            r_v = ($urandom_range(0, 3) != 0);
            r_p = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            r_r = ($urandom_range(0, 2) == 0);
            if (m_phase == M_IDLE) r_v = r_s ? 1'b0 : ($urandom_range(0, 15) == 0);
            drive(r_s, r_l, r_v, r_p, r_r);
        end
        drive(1'b0, 8'd0, 1'b0, 32'd0, 1'b1);
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
